fp_addsub_rne: RTL and testbench
================================

Name: fp_addsub_rne

Overview:
- Parametrised multi-cycle IEEE-754 floating-point adder/subtractor for the custom-instruction datapath.
- Generalises the single-precision adder in four ways: configurable exponent/mantissa width, add/subtract mode, round-to-nearest-even with exception flags, and correct Inf/NaN handling.
- Runs a handshake FSM (enable in, done pulse out), so the host CPU stalls on `busy`.

Parameters:
- EXP_W, 8, exponent field width (>=3).
- MAN_W, 23, stored fraction width (>=4); word width W = 1+EXP_W+MAN_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- enable  input  1  start request; sampled only in IDLE.
- sub  input  1  0: dataa+datab, 1: dataa-datab (datab sign inverted at capture).
- dataa  input  W  operand A.
- datab  input  W  operand B.
- result  output  W  registered result; holds until next done.
- done  output  1  one-cycle pulse, result/flags valid.
- busy  output  1  high whenever state != IDLE.
- flags  output  3  {invalid, overflow, inexact}, registered with result.

Behaviour:
- Reset (async, any state): state=IDLE; result=0, flags=0, done=0, busy=0; all internal regs cleared; an in-flight operation is discarded, with no done.
- States:
  - IDLE: on enable, capture operands (B sign XOR sub).
    - If either operand is special or zero -> SPECIAL.
    - Otherwise -> ALIGN.
  - SPECIAL: compute the special result -> DONE.
  - ALIGN: swap so the larger magnitude is "big" (compare exponent then fraction); right-shift the small significand (hidden 1 prepended) by the exponent difference into a MAN_W+4 bit field {sig, G, R, S}. S = OR of all bits shifted past R. Shift >= MAN_W+3 leaves only S. -> ADD.
  - ADD: same effective sign -> add; else big-small (result never negative). -> NORM.
  - NORM: one action per cycle.
    - Carry-out: shift right 1, fold the lost bit into S, exp+1 -> ROUND.
    - Else if MSB set -> ROUND.
    - Else if sum == 0 -> DONE with +0.
    - Else shift left 1, exp-1.
    - If exp reaches 0 while shifting: flush to signed zero, inexact=1 -> DONE.
  - ROUND: RNE. Increment if G & (R|S|lsb); inexact = G|R|S. Mantissa carry -> exp+1. Exp == all-ones after rounding -> signed Inf, overflow=1, inexact=1. -> DONE.
  - DONE: done=1 for exactly this cycle, result/flags already registered -> IDLE.
- Latency (enable edge to done-high cycle):
  - SPECIAL path: 2 cycles.
  - Normal path: 5+k cycles, k = left shifts in NORM (0..MAN_W+1).
  - The worst case is bounded by MAN_W+7.
- enable while busy (including the DONE cycle) is ignored, and operands are not re-captured. Back-to-back start is possible in the cycle after done.
- Operand encoding:
  - exp == 0: treated as signed zero (denormals flushed; no flag).
  - exp == all-ones: Inf if fraction == 0, else NaN.
- Special-path results:
  - Any NaN -> canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0); invalid=0.
  - Inf + (-Inf) after sub-inversion -> canonical qNaN, invalid=1.
  - Inf op finite -> that Inf. Inf op same-sign Inf -> that Inf.
  - Zero op X -> X (with inverted sign if X is B and sub=1).
  - (+0)+(-0) -> +0. (-0)+(-0) -> -0.
- Exact cancellation of non-zero operands gives +0, flags=0.
- flags are cleared at capture and only ever set, never accumulated across operations.

Test Plan (EXP_W=8, MAN_W=23):
- 1.0 + 2.0: dataa=0x3F800000, datab=0x40000000, sub=0 -> result=0x40400000, flags=000, done at cycle 5, busy high cycles 1-5.
- Rounding ties:
  - 0x3F800000 + 0x33800000 -> 0x3F800000, inexact=1 (tie to even).
  - 0x3F800001 + 0x33800000 -> 0x3F800002, inexact=1.
- Subtraction and cancellation:
  - sub=1, 0x3F800000 - 0x3F7FFFFF -> 0x33800000, flags=000, done within 30 cycles.
  - 0x40490FDB - 0x40490FDB -> 0x00000000.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags=011.
- Specials:
  - sub=1, 0x7F800000 - 0x7F800000 -> 0x7FC00000, flags=100, latency 2.
  - 0x7FA00000 + 0x3F800000 -> 0x7FC00000, flags=000.
  - 0x80000000 + 0x80000000 -> 0x80000000.
- Control:
  - Pulse enable again during busy with different operands -> ignored; first result delivered.
  - Assert rst during NORM -> result=0, done never pulses, busy=0 immediately.
  - After rst deasserts, a new enable completes normally.

Source files
------------

// File: rtl/fp_addsub_rne_if.sv
// Handshake/data bundle for the multi-cycle floating-point adder/subtractor.
// The host drives the master side; the arithmetic unit sits on the slave side.
interface fp_addsub_rne_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         enable;
  logic         sub;
  logic [W-1:0] dataa;
  logic [W-1:0] datab;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic [2:0]   flags;

  modport master (output enable, sub, dataa, datab, input result, done, busy, flags);
  modport slave  (input enable, sub, dataa, datab, output result, done, busy, flags);
endinterface

// File: rtl/fp_addsub_rne.sv
// Parametrised multi-cycle IEEE-754 add/subtract with round-to-nearest-even,
// Inf/NaN handling and {invalid, overflow, inexact} flags.
module fp_addsub_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic            clk,
  input logic            rst,
  fp_addsub_rne_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int F = MAN_W + 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SPECIAL = 3'd1;
  localparam logic [2:0] S_ALIGN   = 3'd2;
  localparam logic [2:0] S_ADD     = 3'd3;
  localparam logic [2:0] S_NORM    = 3'd4;
  localparam logic [2:0] S_ROUND   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W:0]   EXP_INC  = (EXP_W+1)'(1);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic [2:0]     state;
  logic [W-1:0]   a_reg, b_reg, result_r;
  logic [2:0]     flags_r;
  logic           sign_r, eff_sub;
  logic [EXP_W:0] exp_r;
  logic [F-1:0]   big_f, small_f;
  logic [F:0]     sum_r;

  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb, in_ea, in_eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, in_special;

  assign sa = a_reg[W-1];
  assign sb = b_reg[W-1];
  assign ea = a_reg[W-2:MAN_W];
  assign eb = b_reg[W-2:MAN_W];
  assign fa = a_reg[MAN_W-1:0];
  assign fb = b_reg[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);

  assign in_ea = bus.dataa[W-2:MAN_W];
  assign in_eb = bus.datab[W-2:MAN_W];
  assign in_special = (in_ea == '0) || (in_ea == EXP_ONES) || (in_eb == '0) || (in_eb == EXP_ONES);

  logic [W-1:0] spec_result;
  logic [2:0]   spec_flags;

  always_comb begin
    spec_result = a_reg;
    spec_flags  = 3'b000;
    if (a_nan || b_nan) begin
      spec_result = QNAN;
    end else if (a_inf && b_inf) begin
      if (sa != sb) begin
        spec_result = QNAN;
        spec_flags  = 3'b100;
      end
    end else if (a_inf) begin
      spec_result = a_reg;
    end else if (b_inf) begin
      spec_result = b_reg;
    end else if (a_zero && b_zero) begin
      spec_result = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_result = b_reg;
    end
  end

  // Alignment: the smaller operand is shifted into {sig, G, R, S}; everything
  // falling below R is OR-ed into the sticky bit.
  logic               a_big;
  logic [EXP_W-1:0]   e_big, e_small, diff;
  logic [MAN_W-1:0]   f_big, f_small;
  logic [2*F-1:0]     wide;
  logic [F-1:0]       small_al;

  always_comb begin
    a_big   = ({ea, fa} >= {eb, fb});
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    f_big   = a_big ? fa : fb;
    f_small = a_big ? fb : fa;
    diff    = e_big - e_small;
    wide    = {{1'b1, f_small, 3'b000}, {F{1'b0}}} >> diff;
    if (int'(diff) >= MAN_W + 3) begin
      small_al = F'(1);
    end else begin
      small_al = {wide[2*F-1:F+1], wide[F] | (|wide[F-1:0])};
    end
  end

  logic [MAN_W:0]   mant;
  logic             g_bit, r_bit, s_bit, inc;
  logic [MAN_W+1:0] rounded;
  logic [EXP_W:0]   exp_fin;
  logic [MAN_W-1:0] frac_fin;
  logic             ovf;

  always_comb begin
    mant     = sum_r[F-1:3];
    g_bit    = sum_r[2];
    r_bit    = sum_r[1];
    s_bit    = sum_r[0];
    inc      = g_bit & (r_bit | s_bit | mant[0]);
    rounded  = {1'b0, mant} + (MAN_W+2)'(inc);
    exp_fin  = exp_r + (EXP_W+1)'(rounded[MAN_W+1]);
    frac_fin = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    ovf      = (exp_fin >= {1'b0, EXP_ONES});
  end

  // Main sequencer; NORM performs exactly one shift decision per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      result_r <= '0;
      flags_r  <= '0;
      sign_r   <= 1'b0;
      eff_sub  <= 1'b0;
      exp_r    <= '0;
      big_f    <= '0;
      small_f  <= '0;
      sum_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.enable) begin
            a_reg   <= bus.dataa;
            b_reg   <= {bus.datab[W-1] ^ bus.sub, bus.datab[W-2:0]};
            flags_r <= 3'b000;
            state   <= in_special ? S_SPECIAL : S_ALIGN;
          end
        end
        S_SPECIAL: begin
          result_r <= spec_result;
          flags_r  <= spec_flags;
          state    <= S_DONE;
        end
        S_ALIGN: begin
          big_f   <= {1'b1, f_big, 3'b000};
          small_f <= small_al;
          exp_r   <= {1'b0, e_big};
          sign_r  <= a_big ? sa : sb;
          eff_sub <= sa ^ sb;
          state   <= S_ADD;
        end
        S_ADD: begin
          sum_r <= eff_sub ? ({1'b0, big_f} - {1'b0, small_f}) : ({1'b0, big_f} + {1'b0, small_f});
          state <= S_NORM;
        end
        S_NORM: begin
          if (sum_r[F]) begin
            sum_r <= {1'b0, sum_r[F:2], sum_r[1] | sum_r[0]};
            exp_r <= exp_r + EXP_INC;
            state <= S_ROUND;
          end else if (sum_r[F-1]) begin
            state <= S_ROUND;
          end else if (sum_r == '0) begin
            result_r <= '0;
            flags_r  <= 3'b000;
            state    <= S_DONE;
          end else if (exp_r == EXP_INC) begin
            result_r <= {sign_r, {(W-1){1'b0}}};
            flags_r  <= 3'b001;
            state    <= S_DONE;
          end else begin
            sum_r <= {sum_r[F-1:0], 1'b0};
            exp_r <= exp_r - EXP_INC;
          end
        end
        S_ROUND: begin
          if (ovf) begin
            result_r <= {sign_r, EXP_ONES, {MAN_W{1'b0}}};
            flags_r  <= 3'b011;
          end else begin
            result_r <= {sign_r, exp_fin[EXP_W-1:0], frac_fin};
            flags_r  <= {2'b00, g_bit | r_bit | s_bit};
          end
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.result = result_r;
  assign bus.flags  = flags_r;
  assign bus.done   = (state == S_DONE);
  assign bus.busy   = (state != S_IDLE);
endmodule

// File: tb/tb_fp_addsub_rne.sv
// Directed scoreboard bench for fp_addsub_rne in single-precision configuration.
module tb_fp_addsub_rne;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_addsub_rne_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_addsub_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] result;
    logic [2:0]   flags;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic compare(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drives one start request; returns at the falling edge of the first busy cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    bus.dataa  = a;
    bus.datab  = b;
    bus.sub    = s;
    bus.enable = 1'b1;
    @(negedge clk);
    bus.enable = 1'b0;
  endtask

  task automatic apply_stimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic [W-1:0] res, input logic [2:0] fl);
    exp_t e;
    e.result = res;
    e.flags  = fl;
    sb.push_back(e);
    start_op(a, b, s);
    compare({tag, "_busy"}, W'(bus.busy), W'(1));
  endtask

  task automatic check_output(input string tag, input int max_lat, input int exp_lat);
    exp_t e;
    int   lat = 1;
    while (bus.done !== 1'b1 && lat < max_lat) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    assert (bus.done === 1'b1) else begin
      n_fail++;
      $error("[TB] FAIL %s_timeout: observed done=%b expected done=1 within %0d cycles", tag, bus.done, max_lat);
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("[TB] FAIL %s_scoreboard: observed empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      if (bus.done === 1'b1) begin
        compare({tag, "_result"}, bus.result, e.result);
        compare({tag, "_flags"}, W'(bus.flags), W'(e.flags));
        compare({tag, "_busy_at_done"}, W'(bus.busy), W'(1));
        if (exp_lat > 0) compare({tag, "_latency"}, W'(lat), W'(exp_lat));
      end
    end
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    compare(tag, W'(seen), W'(0));
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.sub    = 1'b0;
    bus.dataa  = '0;
    bus.datab  = '0;
    repeat (2) @(negedge clk);
    compare("reset_result", bus.result, '0);
    compare("reset_flags", W'(bus.flags), W'(0));
    compare("reset_done", W'(bus.done), W'(0));
    compare("reset_busy", W'(bus.busy), W'(0));
    rst = 1'b0;

    apply_stimulus("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
    check_output("one_plus_two", 20, 5);

    apply_stimulus("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
    check_output("tie_even", 20, 5);

    apply_stimulus("tie_odd", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
    check_output("tie_odd", 20, 5);

    apply_stimulus("sub_near", 32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000);
    check_output("sub_near", 30, 29);

    apply_stimulus("sub_cancel", 32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 3'b000);
    check_output("sub_cancel", 30, 0);

    apply_stimulus("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
    check_output("overflow", 20, 5);

    apply_stimulus("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
    check_output("inf_minus_inf", 10, 2);

    apply_stimulus("snan_plus_one", 32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
    check_output("snan_plus_one", 10, 2);

    apply_stimulus("negzero_sum", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    check_output("negzero_sum", 10, 2);

    apply_stimulus("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
    check_output("inf_plus_one", 10, 2);

    apply_stimulus("zero_minus_one", 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000);
    check_output("zero_minus_one", 10, 2);

    apply_stimulus("two_minus_one", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000);
    check_output("two_minus_one", 20, 6);

    // Second request while busy and another during the done cycle must both be dropped.
    apply_stimulus("busy_ignore", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
    @(negedge clk);
    bus.dataa  = 32'h40A00000;
    bus.datab  = 32'h40A00000;
    bus.enable = 1'b1;
    @(negedge clk);
    bus.enable = 1'b0;
    check_output("busy_ignore", 20, 0);
    bus.enable = 1'b1;
    @(negedge clk);
    bus.enable = 1'b0;
    expect_no_done("busy_ignore_no_second_done", 12);
    compare("busy_ignore_result_held", bus.result, 32'h40400000);

    // Reset in the middle of a long normalisation discards the operation.
    start_op(32'h3F800000, 32'h3F7FFFFF, 1'b1);
    repeat (3) @(negedge clk);
    compare("pre_reset_busy", W'(bus.busy), W'(1));
    rst = 1'b1;
    #1;
    compare("midreset_busy", W'(bus.busy), W'(0));
    compare("midreset_result", bus.result, '0);
    compare("midreset_flags", W'(bus.flags), W'(0));
    compare("midreset_done", W'(bus.done), W'(0));
    @(negedge clk);
    rst = 1'b0;
    expect_no_done("midreset_no_done", 40);

    apply_stimulus("after_reset", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
    check_output("after_reset", 20, 5);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
